// File: rtl/data_write_sched_pkg.sv
// ---------------------------------------------------------------------------
// data_write_sched_pkg
//   Shared definitions for the data-write store scheduler:
//     - store-entry field widths (address, strobe, data) and packed entry type
//     - requester IDs used by the round-robin arbiter
//     - clog2 helper used to size the occupancy counter and FIFO pointers
// ---------------------------------------------------------------------------
package data_write_sched_pkg;

  localparam int ADDR_W = 32;
  localparam int STRB_W = 4;
  localparam int DATA_W = 32;

  // Requester IDs; also the encoding of the arbiter's last-grant register.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] data;
  } store_t;

  // Ceiling log2 for elaboration-time sizing (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_write_sched_rr.sv
// ---------------------------------------------------------------------------
// data_write_sched_rr
//   Two-input round-robin arbiter for the store buffer's single enqueue slot.
//   When both requesters are active the one not granted last time wins; a
//   lone requester wins whenever space is available. The last-grant register
//   only moves on an actual grant.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   req_core_i    core requests a slot
//   req_aux_i     aux requests a slot
//   space_i       buffer can accept a store this cycle
//   gnt_core_o    core granted (combinational)
//   gnt_aux_o     aux granted (combinational)
//   last_gnt_o    last-grant state (REQ_CORE / REQ_AUX), for observation
// ---------------------------------------------------------------------------
module data_write_sched_rr
  import data_write_sched_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic req_core_i,
  input  logic req_aux_i,
  input  logic space_i,
  output logic gnt_core_o,
  output logic gnt_aux_o,
  output logic last_gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_core_o = 1'b0;
    gnt_aux_o  = 1'b0;
    last_d     = last_q;
    if (space_i) begin
      if (req_core_i && req_aux_i) begin
        if (last_q == REQ_AUX) gnt_core_o = 1'b1;
        else                   gnt_aux_o  = 1'b1;
      end else begin
        gnt_core_o = req_core_i;
        gnt_aux_o  = req_aux_i;
      end
    end
    if (gnt_core_o)     last_d = REQ_CORE;
    else if (gnt_aux_o) last_d = REQ_AUX;
  end

  // Reset to "aux granted last" so the core wins the first contended cycle.
  always_ff @(posedge CLK) begin
    if (RST) last_q <= REQ_AUX;
    else     last_q <= last_d;
  end

  assign last_gnt_o = last_q;

endmodule

// File: rtl/data_write_sched.sv
// ---------------------------------------------------------------------------
// data_write_sched
//   Store scheduler between the memory-write pipeline stage (core), an
//   auxiliary requester (coprocessor/debug) and the MMU data-write port.
//   Accepted stores are buffered in an in-order FIFO of DEPTH entries and
//   drained to the MMU head-first.
//
//   Handshakes:
//     enqueue - a request is accepted in the cycle its grant is high; the
//               core sees CORE_WAIT=0, the aux sees AUX_WREADY=1. Requesters
//               hold their request stable until accepted.
//     dequeue - MMU_WVALID/MMU_W* present the head entry; it is popped in any
//               cycle with MMU_WVALID && MMU_WREADY. MMU_W* stay stable while
//               MMU_WVALID=1 and MMU_WREADY=0.
//   A full buffer still accepts a store in a cycle where the head pops.
//
// Ports:
//   CLK, RST                             clock, synchronous active-high reset
//   CORE_WREN/WADDR/WSTRB/WDATA, CORE_WAIT   core store request / stall
//   AUX_WREN/WADDR/WSTRB/WDATA, AUX_WREADY   aux store request / accept
//   MMU_WVALID/WADDR/WSTRB/WDATA, MMU_WREADY head entry to the MMU
//   EMPTY                                buffer empty (registered state)
//   LOOKUP_ADDR, FWD_HIT/STRB/DATA       store-to-load forwarding
//
// Configuration:
//   DATA_WRITE_SCHED_FWD_EN  when defined, FWD_* are driven by a search of
//   all buffered entries (youngest word-address match wins); otherwise FWD_*
//   are tied to 0 and LOOKUP_ADDR is ignored.
// ---------------------------------------------------------------------------
module data_write_sched
  import data_write_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CORE_WREN,
  input  logic [ADDR_W-1:0] CORE_WADDR,
  input  logic [STRB_W-1:0] CORE_WSTRB,
  input  logic [DATA_W-1:0] CORE_WDATA,
  output logic              CORE_WAIT,
  input  logic              AUX_WREN,
  input  logic [ADDR_W-1:0] AUX_WADDR,
  input  logic [STRB_W-1:0] AUX_WSTRB,
  input  logic [DATA_W-1:0] AUX_WDATA,
  output logic              AUX_WREADY,
  output logic              MMU_WVALID,
  output logic [ADDR_W-1:0] MMU_WADDR,
  output logic [STRB_W-1:0] MMU_WSTRB,
  output logic [DATA_W-1:0] MMU_WDATA,
  input  logic              MMU_WREADY,
  output logic              EMPTY,
  input  logic [ADDR_W-1:0] LOOKUP_ADDR,
  output logic              FWD_HIT,
  output logic [STRB_W-1:0] FWD_STRB,
  output logic [DATA_W-1:0] FWD_DATA
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   valid;
  logic   pop;
  logic   space;
  logic   push;
  logic   gnt_core;
  logic   gnt_aux;
  logic   rr_last_unused;
  store_t in_entry;
  store_t head_entry;

  assign valid = (count_q != '0);
  assign pop   = valid & MMU_WREADY;
  // A pop frees the head slot in the same cycle, so a full buffer can still
  // take a store while the occupancy stays unchanged.
  assign space = (count_q < CNT_W'(DEPTH)) | pop;

  data_write_sched_rr u_rr (
    .CLK        (CLK),
    .RST        (RST),
    .req_core_i (CORE_WREN),
    .req_aux_i  (AUX_WREN),
    .space_i    (space),
    .gnt_core_o (gnt_core),
    .gnt_aux_o  (gnt_aux),
    .last_gnt_o (rr_last_unused)
  );

  assign push       = gnt_core | gnt_aux;
  assign CORE_WAIT  = CORE_WREN & ~gnt_core;
  assign AUX_WREADY = gnt_aux;

  always_comb begin
    in_entry = '0;
    if (gnt_aux) begin
      in_entry.addr = AUX_WADDR;
      in_entry.strb = AUX_WSTRB;
      in_entry.data = AUX_WDATA;
    end else begin
      in_entry.addr = CORE_WADDR;
      in_entry.strb = CORE_WSTRB;
      in_entry.data = CORE_WDATA;
    end
  end

  // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH on their own.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop)  head_d = head_q + PTR_W'(1);
    if (push) tail_d = tail_q + PTR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: contents are only observed while counted.
  always_ff @(posedge CLK) begin
    if (push) mem_q[tail_q] <= in_entry;
  end

  assign head_entry = valid ? mem_q[head_q] : '0;
  assign MMU_WVALID = valid;
  assign MMU_WADDR  = head_entry.addr;
  assign MMU_WSTRB  = head_entry.strb;
  assign MMU_WDATA  = head_entry.data;
  assign EMPTY      = ~valid;

`ifdef DATA_WRITE_SCHED_FWD_EN
  // Walk entries oldest to youngest so the last match (youngest) wins. The
  // head is searched even when it pops this cycle; the incoming store is not.
  logic [PTR_W-1:0] fwd_idx;
  logic             unused_lookup_lo;

  assign unused_lookup_lo = ^LOOKUP_ADDR[1:0];

  always_comb begin
    FWD_HIT  = 1'b0;
    FWD_STRB = '0;
    FWD_DATA = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (mem_q[fwd_idx].addr[ADDR_W-1:2] == LOOKUP_ADDR[ADDR_W-1:2])) begin
        FWD_HIT  = 1'b1;
        FWD_STRB = mem_q[fwd_idx].strb;
        FWD_DATA = mem_q[fwd_idx].data;
      end
    end
  end
`else
  logic unused_lookup;

  assign unused_lookup = ^LOOKUP_ADDR;
  assign FWD_HIT       = 1'b0;
  assign FWD_STRB      = '0;
  assign FWD_DATA      = '0;
`endif

endmodule

// File: tb/tb_data_write_sched.sv
// ---------------------------------------------------------------------------
// tb_data_write_sched
//   Self-checking bench for data_write_sched (DEPTH=4). A queue-based
//   reference model checks every non-reset cycle; a vector table and
//   hand-written sequences cover the specific corner cases.
// ---------------------------------------------------------------------------
module tb_data_write_sched;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        CLK;
  logic        RST;
  logic        CORE_WREN;
  logic [31:0] CORE_WADDR;
  logic [3:0]  CORE_WSTRB;
  logic [31:0] CORE_WDATA;
  logic        CORE_WAIT;
  logic        AUX_WREN;
  logic [31:0] AUX_WADDR;
  logic [3:0]  AUX_WSTRB;
  logic [31:0] AUX_WDATA;
  logic        AUX_WREADY;
  logic        MMU_WVALID;
  logic [31:0] MMU_WADDR;
  logic [3:0]  MMU_WSTRB;
  logic [31:0] MMU_WDATA;
  logic        MMU_WREADY;
  logic        EMPTY;
  logic [31:0] LOOKUP_ADDR;
  logic        FWD_HIT;
  logic [3:0]  FWD_STRB;
  logic [31:0] FWD_DATA;

  data_write_sched #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .CORE_WREN(CORE_WREN), .CORE_WADDR(CORE_WADDR), .CORE_WSTRB(CORE_WSTRB),
    .CORE_WDATA(CORE_WDATA), .CORE_WAIT(CORE_WAIT),
    .AUX_WREN(AUX_WREN), .AUX_WADDR(AUX_WADDR), .AUX_WSTRB(AUX_WSTRB),
    .AUX_WDATA(AUX_WDATA), .AUX_WREADY(AUX_WREADY),
    .MMU_WVALID(MMU_WVALID), .MMU_WADDR(MMU_WADDR), .MMU_WSTRB(MMU_WSTRB),
    .MMU_WDATA(MMU_WDATA), .MMU_WREADY(MMU_WREADY),
    .EMPTY(EMPTY), .LOOKUP_ADDR(LOOKUP_ADDR),
    .FWD_HIT(FWD_HIT), .FWD_STRB(FWD_STRB), .FWD_DATA(FWD_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  // Entry packing: {addr[31:0], strb[3:0], data[31:0]} -> [67:36],[35:32],[31:0]
  logic [67:0] exp_q[$];
  logic        m_last_aux;
  logic        m_gcore;
  logic        m_gaux;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dat_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [3:0] strb_of(input logic [31:0] a);
    return a[5:2];
  endfunction

  // Before the edge: decide grants from buffer occupancy and compare outputs.
  task automatic at_neg();
    int          n;
    logic        space;
    logic [67:0] hd;
    logic        e_hit;
    logic [3:0]  e_strb;
    logic [31:0] e_data;
    @(negedge CLK);
    if (RST) begin
      m_gcore = 1'b0;
      m_gaux  = 1'b0;
    end else begin
      n     = exp_q.size();
      space = (n < DEPTH) || (n > 0 && MMU_WREADY);
      m_gcore = CORE_WREN && space && (!AUX_WREN || m_last_aux);
      m_gaux  = AUX_WREN && space && (!CORE_WREN || !m_last_aux);
      hd = (n > 0) ? exp_q[0] : 68'h0;
      chk("core_wait",  {31'b0, CORE_WAIT},  {31'b0, CORE_WREN && !m_gcore});
      chk("aux_wready", {31'b0, AUX_WREADY}, {31'b0, m_gaux});
      chk("mmu_wvalid", {31'b0, MMU_WVALID}, {31'b0, n > 0});
      chk("empty",      {31'b0, EMPTY},      {31'b0, n == 0});
      chk("mmu_waddr",  MMU_WADDR, hd[67:36]);
      chk("mmu_wstrb",  {28'b0, MMU_WSTRB}, {28'b0, hd[35:32]});
      chk("mmu_wdata",  MMU_WDATA, hd[31:0]);
      e_hit = 1'b0; e_strb = 4'h0; e_data = 32'h0;
`ifdef DATA_WRITE_SCHED_FWD_EN
      for (int i = 0; i < n; i++) begin
        if (exp_q[i][67:38] == LOOKUP_ADDR[31:2]) begin
          e_hit = 1'b1; e_strb = exp_q[i][35:32]; e_data = exp_q[i][31:0];
        end
      end
`endif
      chk("fwd_hit",  {31'b0, FWD_HIT}, {31'b0, e_hit});
      chk("fwd_strb", {28'b0, FWD_STRB}, {28'b0, e_strb});
      chk("fwd_data", FWD_DATA, e_data);
    end
  endtask

  // At the edge: apply the pop and the granted push to the model.
  task automatic at_pos();
    @(posedge CLK);
    if (RST) begin
      exp_q.delete();
      m_last_aux = 1'b1;
    end else begin
      if (exp_q.size() != 0 && MMU_WREADY) void'(exp_q.pop_front());
      if (m_gcore) begin
        exp_q.push_back({CORE_WADDR, CORE_WSTRB, CORE_WDATA});
        m_last_aux = 1'b0;
      end else if (m_gaux) begin
        exp_q.push_back({AUX_WADDR, AUX_WSTRB, AUX_WDATA});
        m_last_aux = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cycle();
    at_neg();
    at_pos();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_core(input logic en, input logic [31:0] a);
    CORE_WREN = en; CORE_WADDR = a; CORE_WSTRB = strb_of(a); CORE_WDATA = dat_of(a);
  endtask

  task automatic drive_aux(input logic en, input logic [31:0] a);
    AUX_WREN = en; AUX_WADDR = a; AUX_WSTRB = strb_of(a); AUX_WDATA = dat_of(a);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive_core(1'b0, 32'h0);
    drive_aux(1'b0, 32'h0);
    MMU_WREADY = 1'b0;
    LOOKUP_ADDR = 32'h0;
    cycle();
    cycle();
    RST = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        cw;
    logic [31:0] ca;
    logic        aw;
    logic [31:0] aa;
    logic        wr;
    logic        e_cwait;
    logic        e_ardy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_empty;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic cw, input logic [31:0] ca, input logic aw,
                              input logic [31:0] aa, input logic wr, input logic e_cwait,
                              input logic e_ardy, input logic e_valid,
                              input logic [31:0] e_addr, input logic e_empty);
    vec_t v;
    v.cw = cw; v.ca = ca; v.aw = aw; v.aa = aa; v.wr = wr;
    v.e_cwait = e_cwait; v.e_ardy = e_ardy; v.e_valid = e_valid;
    v.e_addr = e_addr; v.e_empty = e_empty;
    return v;
  endfunction

  logic [31:0] rnd_core_a;
  logic [31:0] rnd_aux_a;

  initial begin
    m_last_aux = 1'b1;
    m_gcore = 1'b0;
    m_gaux = 1'b0;

    // Fill pattern, then full, then full-with-pop, then contention, then drain.
    tbl[0]  = mk(1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 32'h0,   1);
    tbl[1]  = mk(1, 32'h104, 0, 32'h0,   0, 0, 0, 1, 32'h100, 0);
    tbl[2]  = mk(1, 32'h108, 0, 32'h0,   0, 0, 0, 1, 32'h100, 0);
    tbl[3]  = mk(1, 32'h10C, 0, 32'h0,   0, 0, 0, 1, 32'h100, 0);
    tbl[4]  = mk(1, 32'h110, 0, 32'h0,   0, 1, 0, 1, 32'h100, 0);
    tbl[5]  = mk(1, 32'h110, 0, 32'h0,   0, 1, 0, 1, 32'h100, 0);
    tbl[6]  = mk(1, 32'h110, 0, 32'h0,   1, 0, 0, 1, 32'h100, 0);
    tbl[7]  = mk(0, 32'h0,   0, 32'h0,   1, 0, 0, 1, 32'h104, 0);
    tbl[8]  = mk(0, 32'h0,   1, 32'h200, 0, 0, 1, 1, 32'h108, 0);
    tbl[9]  = mk(1, 32'h114, 1, 32'h204, 0, 1, 0, 1, 32'h108, 0);
    tbl[10] = mk(1, 32'h114, 1, 32'h204, 1, 0, 0, 1, 32'h108, 0);
    tbl[11] = mk(0, 32'h0,   1, 32'h204, 1, 0, 1, 1, 32'h10C, 0);
    tbl[12] = mk(0, 32'h0,   0, 32'h0,   1, 0, 0, 1, 32'h110, 0);
    tbl[13] = mk(0, 32'h0,   0, 32'h0,   1, 0, 0, 1, 32'h200, 0);
    tbl[14] = mk(0, 32'h0,   0, 32'h0,   1, 0, 0, 1, 32'h114, 0);
    tbl[15] = mk(0, 32'h0,   0, 32'h0,   1, 0, 0, 1, 32'h204, 0);
    tbl[16] = mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1);

    // ---- reset state + single store ----
    do_reset();
    at_neg();
    chk("rst_wvalid", {31'b0, MMU_WVALID}, 32'd0);
    chk("rst_empty",  {31'b0, EMPTY},      32'd1);
    chk("rst_waddr",  MMU_WADDR,           32'h0);
    chk("rst_fwd",    {31'b0, FWD_HIT},    32'd0);
    at_pos();
    CORE_WREN = 1'b1; CORE_WADDR = 32'h1000; CORE_WSTRB = 4'hF; CORE_WDATA = 32'hDEADBEEF;
    MMU_WREADY = 1'b1;
    at_neg();
    chk("single_core_wait", {31'b0, CORE_WAIT}, 32'd0);
    chk("single_empty_same_cycle", {31'b0, EMPTY}, 32'd1);
    at_pos();
    CORE_WREN = 1'b0;
    at_neg();
    chk("single_wvalid", {31'b0, MMU_WVALID}, 32'd1);
    chk("single_waddr",  MMU_WADDR, 32'h1000);
    chk("single_wstrb",  {28'b0, MMU_WSTRB}, 32'hF);
    chk("single_wdata",  MMU_WDATA, 32'hDEADBEEF);
    at_pos();
    at_neg();
    chk("single_empty_after", {31'b0, EMPTY}, 32'd1);
    at_pos();

    // ---- table: full / full-with-pop / contention ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_core(tbl[i].cw, tbl[i].ca);
      drive_aux(tbl[i].aw, tbl[i].aa);
      MMU_WREADY = tbl[i].wr;
      at_neg();
      chk($sformatf("tbl%0d_core_wait", i), {31'b0, CORE_WAIT}, {31'b0, tbl[i].e_cwait});
      chk($sformatf("tbl%0d_aux_wready", i), {31'b0, AUX_WREADY}, {31'b0, tbl[i].e_ardy});
      chk($sformatf("tbl%0d_wvalid", i), {31'b0, MMU_WVALID}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_waddr", i), MMU_WADDR, tbl[i].e_addr);
      chk($sformatf("tbl%0d_wdata", i), MMU_WDATA,
          tbl[i].e_valid ? dat_of(tbl[i].e_addr) : 32'h0);
      chk($sformatf("tbl%0d_wstrb", i), {28'b0, MMU_WSTRB},
          tbl[i].e_valid ? {28'b0, strb_of(tbl[i].e_addr)} : 32'h0);
      chk($sformatf("tbl%0d_empty", i), {31'b0, EMPTY}, {31'b0, tbl[i].e_empty});
      at_pos();
    end

    // ---- alternating grants, both requesting every cycle ----
    do_reset();
    rnd_core_a = 32'h500;
    rnd_aux_a  = 32'h600;
    MMU_WREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_core(1'b1, rnd_core_a);
      drive_aux(1'b1, rnd_aux_a);
      at_neg();
      chk($sformatf("alt%0d_core_wait", i), {31'b0, CORE_WAIT}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_aux_wready", i), {31'b0, AUX_WREADY}, (i % 2 == 1) ? 32'd1 : 32'd0);
      at_pos();
      if (i % 2 == 0) rnd_core_a = rnd_core_a + 32'd4;
      else            rnd_aux_a  = rnd_aux_a + 32'd4;
    end
    drive_core(1'b0, 32'h0);
    drive_aux(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle();

    // ---- head held stable while stalled ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_core(1'b1, 32'h700 + 32'(4 * i));
      cycle();
    end
    drive_core(1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk($sformatf("hold%0d_waddr", i), MMU_WADDR, 32'h700);
      chk($sformatf("hold%0d_wdata", i), MMU_WDATA, dat_of(32'h700));
      chk($sformatf("hold%0d_wstrb", i), {28'b0, MMU_WSTRB}, {28'b0, strb_of(32'h700)});
      at_pos();
    end
    MMU_WREADY = 1'b1;
    cycle();
    MMU_WREADY = 1'b0;
    at_neg();
    chk("hold_advance_waddr", MMU_WADDR, 32'h704);
    at_pos();

    // ---- forwarding ----
    do_reset();
    CORE_WREN = 1'b1; CORE_WADDR = 32'h2004; CORE_WSTRB = 4'hF; CORE_WDATA = 32'h11;
    cycle();
    CORE_WADDR = 32'h2006; CORE_WSTRB = 4'b1100; CORE_WDATA = 32'h22220000;
    cycle();
    CORE_WREN = 1'b0;
    LOOKUP_ADDR = 32'h2005;
    at_neg();
`ifdef DATA_WRITE_SCHED_FWD_EN
    chk("fwd_hit_2005",  {31'b0, FWD_HIT}, 32'd1);
    chk("fwd_strb_2005", {28'b0, FWD_STRB}, 32'hC);
    chk("fwd_data_2005", FWD_DATA, 32'h22220000);
`else
    chk("fwd_off_hit_2005",  {31'b0, FWD_HIT}, 32'd0);
    chk("fwd_off_data_2005", FWD_DATA, 32'h0);
`endif
    at_pos();
    LOOKUP_ADDR = 32'h3000;
    at_neg();
    chk("fwd_hit_3000", {31'b0, FWD_HIT}, 32'd0);
    at_pos();
    MMU_WREADY = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // ---- reset mid-operation ----
    MMU_WREADY = 1'b0;
    LOOKUP_ADDR = 32'h0;
    for (int i = 0; i < 3; i++) begin
      drive_core(1'b1, 32'h800 + 32'(4 * i));
      cycle();
    end
    drive_core(1'b0, 32'h0);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    at_neg();
    chk("midrst_wvalid", {31'b0, MMU_WVALID}, 32'd0);
    chk("midrst_empty",  {31'b0, EMPTY},      32'd1);
    at_pos();
    MMU_WREADY = 1'b1;
    drive_core(1'b1, 32'h900);
    cycle();
    drive_core(1'b1, 32'h904);
    cycle();
    drive_core(1'b0, 32'h0);
    at_neg();
    chk("midrst_drain_waddr", MMU_WADDR, 32'h904);
    at_pos();
    cycle();

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (!CORE_WREN || m_gcore) begin
        rnd_core_a = 32'h4000 + 32'($urandom_range(0, 127));
        CORE_WREN  = ($urandom_range(0, 2) != 0);
        CORE_WADDR = rnd_core_a;
        CORE_WSTRB = 4'($urandom_range(0, 15));
        CORE_WDATA = $urandom;
      end
      if (!AUX_WREN || m_gaux) begin
        rnd_aux_a = 32'h4000 + 32'($urandom_range(0, 127));
        AUX_WREN  = ($urandom_range(0, 2) == 0);
        AUX_WADDR = rnd_aux_a;
        AUX_WSTRB = 4'($urandom_range(0, 15));
        AUX_WDATA = $urandom;
      end
      MMU_WREADY  = ($urandom_range(0, 9) < 6);
      LOOKUP_ADDR = 32'h4000 + 32'($urandom_range(0, 127));
      cycle();
    end
    drive_core(1'b0, 32'h0);
    drive_aux(1'b0, 32'h0);
    MMU_WREADY = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("final_model_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
